// File: rtl/riscv_v_lmul_sequencer_pkg.sv
// Shared types for the LMUL register-group sequencer: FSM state,
// LMUL/SEW encodings and the micro-op record seen by execute.
package riscv_v_pkg;

  localparam int UOP_EB_W = 16;  // holds elem_base for VLEN up to 32768

  typedef enum logic {IDLE, ISSUE} riscv_v_seq_state_e;

  typedef logic [1:0] riscv_v_lmul_t;
  typedef logic [1:0] riscv_v_sew_t;

  typedef struct packed {
    logic [4:0]          vd;
    logic [4:0]          vs1;
    logic [4:0]          vs2;
    logic [2:0]          idx;
    logic [UOP_EB_W-1:0] elem_base;
    logic                first;
    logic                last;
  } riscv_v_uop_t;

endpackage

// File: rtl/riscv_v_lmul_sequencer_if.sv
// Decode-side instruction handshake and execute-side micro-op handshake.
// master = surrounding pipeline, slave = sequencer.
interface riscv_v_lmul_sequencer_if #(
  parameter int ELEM_W = 8
);
  import riscv_v_pkg::*;

  logic              in_valid;
  logic              in_ready;
  riscv_v_lmul_t     in_lmul;
  riscv_v_sew_t      in_sew;
  logic [ELEM_W-1:0] in_vl;
  logic [4:0]        in_vd;
  logic [4:0]        in_vs1;
  logic [4:0]        in_vs2;
  logic              in_is_reduct;
  logic              in_is_mask;
  logic              in_use_vs1;
  logic              flush;

  logic              uop_valid;
  logic              uop_ready;
  logic [4:0]        uop_vd;
  logic [4:0]        uop_vs1;
  logic [4:0]        uop_vs2;
  logic [2:0]        uop_idx;
  logic [ELEM_W-1:0] uop_elem_base;
  logic              uop_first;
  logic              uop_last;
  logic              busy;
  logic              illegal;

  modport master (
    output in_valid, in_lmul, in_sew, in_vl, in_vd, in_vs1, in_vs2,
           in_is_reduct, in_is_mask, in_use_vs1, flush, uop_ready,
    input  in_ready, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_idx,
           uop_elem_base, uop_first, uop_last, busy, illegal
  );

  modport slave (
    input  in_valid, in_lmul, in_sew, in_vl, in_vd, in_vs1, in_vs2,
           in_is_reduct, in_is_mask, in_use_vs1, flush, uop_ready,
    output in_ready, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_idx,
           uop_elem_base, uop_first, uop_last, busy, illegal
  );

endinterface

// File: rtl/riscv_v_lmul_sequencer_uop_count.sv
// Combinational group sizing: elements per register, micro-op count
// (min of group size and registers touched by vl) and alignment legality.
module riscv_v_uop_count
  import riscv_v_pkg::*;
#(
  parameter int VLEN   = 128,
  parameter int ELEM_W = $clog2(VLEN) + 1
) (
  input  riscv_v_lmul_t     lmul_i,
  input  riscv_v_sew_t      sew_i,
  input  logic [ELEM_W-1:0] vl_i,
  input  logic [4:0]        vd_i,
  input  logic [4:0]        vs1_i,
  input  logic [4:0]        vs2_i,
  input  logic              is_reduct_i,
  input  logic              is_mask_i,
  input  logic              use_vs1_i,
  output logic [ELEM_W-1:0] epr_o,
  output logic [3:0]        n_o,
  output logic              legal_o
);

  localparam int EPR_MAX_LOG = $clog2(VLEN / 8);

  logic [ELEM_W:0] regs_needed;
  logic [3:0]      grp;
  logic [4:0]      amask;

  always_comb begin
    epr_o = ELEM_W'((VLEN / 8) >> sew_i);
    // EPR is a power of two, so ceil(vl/EPR) is a rounded-up shift
    regs_needed = ({1'b0, vl_i} + {1'b0, epr_o} - (ELEM_W+1)'(1))
                  >> (EPR_MAX_LOG - int'(sew_i));
    grp   = 4'd1 << lmul_i;
    n_o   = (regs_needed > (ELEM_W+1)'(grp)) ? grp : regs_needed[3:0];
    amask = 5'(grp - 4'd1);
    legal_o = ((vs2_i & amask) == 5'd0)
           && (is_mask_i || is_reduct_i || ((vd_i & amask) == 5'd0))
           && (!use_vs1_i || is_reduct_i || ((vs1_i & amask) == 5'd0));
  end

endmodule

// File: rtl/riscv_v_lmul_sequencer.sv
// Expands one LMUL-grouped vector instruction into per-register micro-ops,
// skipping trailing registers beyond vl and rejecting misaligned groups.
module riscv_v_lmul_sequencer
  import riscv_v_pkg::*;
#(
  parameter int VLEN   = 128,
  parameter int ELEM_W = $clog2(VLEN) + 1
) (
  input logic                      clk,
  input logic                      rst,
  riscv_v_lmul_sequencer_if.slave  bus
);

  riscv_v_seq_state_e state_q, state_d;

  logic [4:0]        vd_q, vs1_q, vs2_q;
  logic [ELEM_W-1:0] epr_q;
  logic [3:0]        n_q;
  logic [2:0]        idx_q;
  logic              red_q, mask_q, use1_q;
  logic              illegal_q;

  logic [ELEM_W-1:0] epr;
  logic [3:0]        n;
  logic              legal;
  logic              issue, fire, last, accept, start, in_ready;
  riscv_v_uop_t      uop;

  riscv_v_uop_count #(.VLEN(VLEN), .ELEM_W(ELEM_W)) u_count (
    .lmul_i      (bus.in_lmul),
    .sew_i       (bus.in_sew),
    .vl_i        (bus.in_vl),
    .vd_i        (bus.in_vd),
    .vs1_i       (bus.in_vs1),
    .vs2_i       (bus.in_vs2),
    .is_reduct_i (bus.in_is_reduct),
    .is_mask_i   (bus.in_is_mask),
    .use_vs1_i   (bus.in_use_vs1),
    .epr_o       (epr),
    .n_o         (n),
    .legal_o     (legal)
  );

  assign issue    = (state_q == ISSUE);
  assign last     = (idx_q == 3'(n_q - 4'd1));
  assign fire     = issue && bus.uop_ready;
  assign in_ready = !rst && !bus.flush && (!issue || (fire && last));
  assign accept   = bus.in_valid && in_ready;
  assign start    = accept && legal && (n != 4'd0);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = ISSUE;
        ISSUE:   if (fire && last) state_d = start ? ISSUE : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // captured instruction and group position
  always_ff @(posedge clk) begin
    if (rst) begin
      vd_q <= '0; vs1_q <= '0; vs2_q <= '0;
      epr_q <= '0; n_q <= '0; idx_q <= '0;
      red_q <= 1'b0; mask_q <= 1'b0; use1_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && !legal;
      if (accept) begin
        vd_q   <= bus.in_vd;
        vs1_q  <= bus.in_vs1;
        vs2_q  <= bus.in_vs2;
        epr_q  <= epr;
        n_q    <= n;
        idx_q  <= 3'd0;
        red_q  <= bus.in_is_reduct;
        mask_q <= bus.in_is_mask;
        use1_q <= bus.in_use_vs1;
      end else if (fire && !last) begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  // outputs: derived only from registered state, so a stall holds them
  always_comb begin
    uop           = '0;
    uop.vs2       = vs2_q + 5'(idx_q);
    uop.vs1       = (use1_q && !red_q) ? vs1_q + 5'(idx_q) : vs1_q;
    uop.vd        = (mask_q || red_q) ? vd_q : vd_q + 5'(idx_q);
    uop.idx       = idx_q;
    uop.elem_base = UOP_EB_W'(epr_q * ELEM_W'(idx_q));
    uop.first     = issue && (idx_q == 3'd0);
    uop.last      = issue && last;
  end

  assign bus.in_ready      = in_ready;
  assign bus.uop_valid     = issue;
  assign bus.busy          = issue;
  assign bus.illegal       = illegal_q;
  assign bus.uop_vd        = uop.vd;
  assign bus.uop_vs1       = uop.vs1;
  assign bus.uop_vs2       = uop.vs2;
  assign bus.uop_idx       = uop.idx;
  assign bus.uop_elem_base = uop.elem_base[ELEM_W-1:0];
  assign bus.uop_first     = uop.first;
  assign bus.uop_last      = uop.last;

endmodule
